matmul_share_arbiter: RTL and testbench
=======================================

Name: matmul_share_arbiter

Overview:
- Shares one sequential_matrix_multiplier core between two requesters.
- Arbitrates round-robin and resets/starts the core per job.
- Steers operand reads and result handshakes to the granted requester, and reports per-requester job completion.
- Sits between the core and the bench-side / system-side matrix stores.

Parameters:
m, 4, matrix dimension (m x m operands and result)
W, 32, data word width
IW, 2, index width, clog2(m)
CLR_CYCLES, 2, cycles core_rst is held at job start

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
req  in  2  job request per requester, level
gnt  out  2  one-hot grant; 00 when idle
job_done  out  2  one-cycle pulse to the finished requester
a_i,a_j,b_i,b_j  out  IW each  operand indices, broadcast (= core indices)
a0_in,b0_in  in  W each  operands from requester 0
a1_in,b1_in  in  W each  operands from requester 1
z_out  out  W  result value, broadcast
z_i,z_j  out  IW each  result indices, broadcast
z_stb  out  2  result strobe, only the granted bit may be 1
z_ack  in  2  result ack per requester
core_rst  out  1  core synchronous reset
core_start  out  1  core start
core_a_in,core_b_in  out  W each  muxed operands to core
core_a_i,core_a_j,core_b_i,core_b_j  in  IW each  core operand indices
core_z_out  in  W  core result
core_z_i,core_z_j  in  IW each  core result indices
core_z_stb  in  1  core result strobe
core_z_ack  out  1  ack to core
core_done  in  1  core finished

Behaviour:
- Reset values: state IDLE, gnt=00, job_done=00, core_start=0, z_stb=00, core_z_ack=0, rr pointer favours requester 0, result counter 0.
- core_rst = rst OR (state==CLR), combinational.
- States:
  - IDLE:
    - req!=0 -> next cycle gnt latched, go to CLR.
    - If both request, grant the requester not served last; after reset requester 0 wins.
  - CLR:
    - core_rst=1 for exactly CLR_CYCLES cycles.
    - Result counter cleared.
    - Then go to RUN.
  - RUN:
    - core_start=1.
    - Leave when core_done=1 AND counter==m*m -> DONE.
  - DONE:
    - One cycle.
    - job_done[g]=1, core_start=0.
    - rr pointer updated to g.
    - Go to IDLE.
    - gnt drops to 00 on the IDLE cycle.
- Minimum one IDLE cycle between jobs; a requester holding req continuously alternates with a competing requester.
- req is sampled only in IDLE. Deasserting req mid-job has no effect; the job completes and job_done still pulses.
- Operand steering, combinational:
  - core_a_in/core_b_in = a{g}_in/b{g}_in for granted g, else 0.
  - Index outputs pass core indices through unchanged in all states.
- Result steering, combinational:
  - z_stb[g] = core_z_stb AND state==RUN; non-granted bit always 0.
  - core_z_ack = z_ack[g] AND state==RUN; non-granted z_ack is ignored.
  - z_out/z_i/z_j pass through.
- Counter: +1 on each cycle with core_z_stb AND core_z_ack in RUN; width clog2(m*m)+1; saturates at m*m.
- core_done before all m*m results are acked keeps the arbiter in RUN until the counter reaches m*m. The ack stall is honoured, not dropped.
- rst in any state: synchronous return to reset values next edge; any in-flight job is abandoned, no job_done pulse; core held in reset while rst=1.
- No combinational path from req to gnt; gnt changes only on clock edges.

Test Plan:
- Single job: req=01 held, core model emits 16 results with immediate ack -> gnt=01 from cycle+1, core_rst high 2 cycles, 16 acked handshakes, job_done=01 for exactly 1 cycle, gnt=00 next cycle.
- Simultaneous request after reset: req=11 -> gnt=01 first job; second job gnt=10; third gnt=01.
- Ack stall: requester 0 withholds z_ack 5 cycles on result (2,3); core asserts core_done early -> core_z_ack low during stall, z_stb[1]=0 throughout, job_done only after 16th handshake.
- Operand mux: a0_in=5, a1_in=9 with gnt=10 -> core_a_in=9; in IDLE core_a_in=0.
- Reset mid-RUN after 7 results -> next edge gnt=00, core_start=0, core_rst=1, no job_done; new req=10 after release runs a full 16-result job.
- req drop: requester 1 deasserts req 3 cycles into RUN -> job completes, job_done=10 pulses.

Source files
------------

// File: rtl/matmul_share_arbiter.sv
// matmul_share_arbiter
// Shares one sequential matrix multiplier core between two requesters.
// Grants jobs round-robin, holds the core in reset for CLR_CYCLES at job
// start, steers operands/results to the granted requester and pulses
// job_done to the finished requester.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   req[1:0]                     job request per requester (level, sampled in IDLE)
//   gnt[1:0], job_done[1:0]      one-hot grant, one-cycle completion pulse
//   a_i,a_j,b_i,b_j              operand indices (core indices passed through)
//   a0_in,b0_in,a1_in,b1_in      operands from requester 0 / 1
//   z_out,z_i,z_j,z_stb,z_ack    result handshake towards requesters
//   core_*                       connection to the shared core
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no job; sample req and latch grant
// CLR   | core held in reset for CLR_CYCLES; result counter cleared
// RUN   | core started; count acked results until done and m*m reached
// DONE  | one cycle: job_done pulse, rr pointer updated, grant released
module matmul_share_arbiter #(
   parameter int m          = 4,
   parameter int W          = 32,
   parameter int IW         = 2,
   parameter int CLR_CYCLES = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [1:0]    req,
   output logic [1:0]    gnt,
   output logic [1:0]    job_done,
   output logic [IW-1:0] a_i,
   output logic [IW-1:0] a_j,
   output logic [IW-1:0] b_i,
   output logic [IW-1:0] b_j,
   input  logic [W-1:0]  a0_in,
   input  logic [W-1:0]  b0_in,
   input  logic [W-1:0]  a1_in,
   input  logic [W-1:0]  b1_in,
   output logic [W-1:0]  z_out,
   output logic [IW-1:0] z_i,
   output logic [IW-1:0] z_j,
   output logic [1:0]    z_stb,
   input  logic [1:0]    z_ack,
   output logic          core_rst,
   output logic          core_start,
   output logic [W-1:0]  core_a_in,
   output logic [W-1:0]  core_b_in,
   input  logic [IW-1:0] core_a_i,
   input  logic [IW-1:0] core_a_j,
   input  logic [IW-1:0] core_b_i,
   input  logic [IW-1:0] core_b_j,
   input  logic [W-1:0]  core_z_out,
   input  logic [IW-1:0] core_z_i,
   input  logic [IW-1:0] core_z_j,
   input  logic          core_z_stb,
   output logic          core_z_ack,
   input  logic          core_done
);

   localparam int CW = $clog2(m*m) + 1;
   localparam int KW = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
   localparam logic [CW-1:0] FULL = CW'(m*m);

   typedef enum logic [1:0] {S_IDLE, S_CLR, S_RUN, S_DONE} state_t;

   state_t        state_q, state_d;
   logic [1:0]    gnt_q, gnt_d;
   logic          rr_q, rr_d;      // index of the requester served last
   logic [CW-1:0] cnt_q, cnt_d;
   logic [KW-1:0] clr_q, clr_d;    // CLR cycles remaining, minus one
   logic          run;

   assign run = (state_q == S_RUN);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         gnt_q   <= 2'b00;
         rr_q    <= 1'b1;          // "last served = 1" makes requester 0 win first
         cnt_q   <= '0;
         clr_q   <= '0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         rr_q    <= rr_d;
         cnt_q   <= cnt_d;
         clr_q   <= clr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      rr_d    = rr_q;
      cnt_d   = cnt_q;
      clr_d   = clr_q;
      case (state_q)
         S_IDLE: begin
            if (req != 2'b00) begin
               state_d = S_CLR;
               clr_d   = KW'(CLR_CYCLES - 1);
               if (req == 2'b11) gnt_d = rr_q ? 2'b01 : 2'b10;
               else              gnt_d = req;
            end
         end
         S_CLR: begin
            cnt_d = '0;
            if (clr_q == '0) state_d = S_RUN;
            else             clr_d   = clr_q - 1'b1;
         end
         S_RUN: begin
            if (core_z_stb && core_z_ack && (cnt_q != FULL)) cnt_d = cnt_q + 1'b1;
            // completion is judged on the count before this cycle's handshake
            if (core_done && (cnt_q == FULL)) state_d = S_DONE;
         end
         S_DONE: begin
            rr_d    = gnt_q[1];
            gnt_d   = 2'b00;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign gnt        = gnt_q;
   assign job_done   = (state_q == S_DONE) ? gnt_q : 2'b00;
   assign core_rst   = rst | (state_q == S_CLR);
   assign core_start = run;
   assign z_stb      = (core_z_stb && run) ? gnt_q : 2'b00;
   assign core_z_ack = run && (|(z_ack & gnt_q));

   always_comb begin
      core_a_in = '0;
      core_b_in = '0;
      if (gnt_q[0]) begin
         core_a_in = a0_in;
         core_b_in = b0_in;
      end else if (gnt_q[1]) begin
         core_a_in = a1_in;
         core_b_in = b1_in;
      end
   end

   assign a_i   = core_a_i;
   assign a_j   = core_a_j;
   assign b_i   = core_b_i;
   assign b_j   = core_b_j;
   assign z_out = core_z_out;
   assign z_i   = core_z_i;
   assign z_j   = core_z_j;

endmodule

// File: tb/tb_matmul_share_arbiter.sv
module tb_matmul_share_arbiter;

   localparam int M  = 4;
   localparam int W  = 32;
   localparam int IW = 2;
   localparam int NR = M*M;

   logic          clk = 1'b0;
   logic          rst, core_rst, core_start, core_z_stb, core_z_ack, core_done;
   logic [1:0]    req, gnt, job_done, z_stb, z_ack;
   logic [IW-1:0] a_i, a_j, b_i, b_j, z_i, z_j;
   logic [IW-1:0] core_a_i, core_a_j, core_b_i, core_b_j, core_z_i, core_z_j;
   logic [W-1:0]  a0_in, b0_in, a1_in, b1_in, z_out, core_a_in, core_b_in, core_z_out;

   always #5 clk = ~clk;

   matmul_share_arbiter #(.m(M), .W(W), .IW(IW), .CLR_CYCLES(2)) dut (
      .clk(clk), .rst(rst), .req(req), .gnt(gnt), .job_done(job_done),
      .a_i(a_i), .a_j(a_j), .b_i(b_i), .b_j(b_j),
      .a0_in(a0_in), .b0_in(b0_in), .a1_in(a1_in), .b1_in(b1_in),
      .z_out(z_out), .z_i(z_i), .z_j(z_j), .z_stb(z_stb), .z_ack(z_ack),
      .core_rst(core_rst), .core_start(core_start),
      .core_a_in(core_a_in), .core_b_in(core_b_in),
      .core_a_i(core_a_i), .core_a_j(core_a_j), .core_b_i(core_b_i), .core_b_j(core_b_j),
      .core_z_out(core_z_out), .core_z_i(core_z_i), .core_z_j(core_z_j),
      .core_z_stb(core_z_stb), .core_z_ack(core_z_ack), .core_done(core_done)
   );

   int checks = 0;
   int failures = 0;

   // stimulus controls
   logic       rst_drv = 1'b1;
   logic [1:0] req_drv = 2'b00;
   int         ack_mode = 0;    // 0 always ack, 1 random ack, 2 stall requester 0 on (2,3)
   int         early_mode = 0;  // 0 never, 1 always, 2 random early core_done
   bit         ops_fixed = 0;
   bit         chk_en = 0;

   // core environment model: emits NR results in order, one per handshake
   bit cm_active = 0;
   bit cm_early = 0;
   int cm_ce = 0;

   // reference model of the arbiter (job-level view)
   int m_owner = -1;    // granted requester, -1 when none
   int m_clr = 0;       // core-reset cycles still to go
   int m_acks = 0;      // results handed over this job
   bit m_end = 0;       // completion cycle pending
   int m_last = 1;      // requester served last

   // per-job observations of the DUT
   int job_rst_cycles, job_hs, job_done_cycles, stall_cnt, stall_seen;
   logic [1:0] job_gnt, last_done, last_gnt;
   logic [W-1:0] last_core_a;
   logic last_core_rst, last_start;
   int done_at;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s t=%0t actual=%0h expected=%0h", nm, $time, act, exp);
      end
   endtask

   task automatic new_job();
      job_rst_cycles = 0; job_hs = 0; job_done_cycles = 0;
      stall_cnt = 0; stall_seen = 0; job_gnt = 2'b00;
   endtask

   task automatic cycle();
      logic [1:0] eg, edone, estb;
      logic [W-1:0] ea, eb;
      bit running, inclr, hs, eack;
      @(negedge clk);
      rst = rst_drv;
      req = req_drv;
      if (ops_fixed) begin
         a0_in = 5; a1_in = 9; b0_in = 7; b1_in = 11;
      end else begin
         a0_in = $urandom; a1_in = $urandom; b0_in = $urandom; b1_in = $urandom;
      end
      core_a_i = IW'($urandom); core_a_j = IW'($urandom);
      core_b_i = IW'($urandom); core_b_j = IW'($urandom);
      core_z_stb = cm_active && (cm_ce < NR);
      core_z_out = 32'hA000_0000 + W'(cm_ce);
      core_z_i   = IW'((cm_ce % NR) / M);
      core_z_j   = IW'(cm_ce % M);
      core_done  = cm_active && ((cm_ce == NR) || (cm_early && cm_ce >= NR/2));
      case (ack_mode)
         0: z_ack = 2'b11;
         1: z_ack = {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)};
         default: begin
            z_ack = 2'b11;
            if (core_z_stb && cm_ce == 11 && stall_cnt < 5) begin
               z_ack[0] = 1'b0;
               stall_cnt++;
            end
         end
      endcase
      #1;
      eg      = (m_owner >= 0) ? (2'b01 << m_owner) : 2'b00;
      inclr   = (m_owner >= 0) && (m_clr > 0);
      running = (m_owner >= 0) && (m_clr == 0) && !m_end;
      edone   = m_end ? eg : 2'b00;
      estb    = (running && core_z_stb) ? eg : 2'b00;
      eack    = running && (m_owner >= 0) && z_ack[m_owner];
      ea      = (m_owner == 0) ? a0_in : (m_owner == 1) ? a1_in : '0;
      eb      = (m_owner == 0) ? b0_in : (m_owner == 1) ? b1_in : '0;
      if (chk_en) begin
         chk("gnt", gnt, eg);
         chk("job_done", job_done, edone);
         chk("core_rst", core_rst, rst | inclr);
         chk("core_start", core_start, running);
         chk("z_stb", z_stb, estb);
         chk("core_z_ack", core_z_ack, eack);
         chk("core_a_in", core_a_in, ea);
         chk("core_b_in", core_b_in, eb);
         chk("idx_pass", {a_i, a_j, b_i, b_j, z_i, z_j},
             {core_a_i, core_a_j, core_b_i, core_b_j, core_z_i, core_z_j});
         chk("z_out", z_out, core_z_out);
      end
      // DUT observations
      last_done = job_done; last_gnt = gnt; last_core_a = core_a_in;
      last_core_rst = core_rst; last_start = core_start;
      if (core_rst && !rst) job_rst_cycles++;
      if (core_z_stb && core_z_ack) job_hs++;
      if (core_z_stb && !core_z_ack && z_stb != 2'b00) stall_seen++;
      if (job_done != 2'b00) job_done_cycles++;
      if (job_gnt == 2'b00) job_gnt = gnt;
      // reference model advances
      hs = eack && core_z_stb;
      if (rst) begin
         m_owner = -1; m_last = 1; m_acks = 0; m_end = 0; m_clr = 0;
      end else if (m_owner < 0) begin
         if (req != 2'b00) begin
            if (req == 2'b11) m_owner = (m_last == 0) ? 1 : 0;
            else              m_owner = req[1] ? 1 : 0;
            m_clr = 2;
            m_acks = 0;
         end
      end else if (m_clr > 0) begin
         m_clr--;
         m_acks = 0;
      end else if (m_end) begin
         m_last = m_owner; m_owner = -1; m_end = 0;
      end else begin
         if (core_done && m_acks == NR) m_end = 1;
         if (hs && m_acks < NR) m_acks++;
      end
      // core environment advances on the DUT's actual controls
      if (core_rst) begin
         cm_active = 0; cm_ce = 0;
      end else if (!cm_active && core_start) begin
         cm_active = 1; cm_ce = 0;
         cm_early = (early_mode == 2) ? bit'($urandom_range(0, 1)) : (early_mode == 1);
      end else if (cm_active && core_z_stb && core_z_ack) begin
         cm_ce++;
      end
   endtask

   task automatic wait_done(input int budget);
      int n;
      bit got;
      n = 0; got = 0;
      while (!got && n < budget) begin
         cycle();
         n++;
         if (last_done != 2'b00) got = 1;
      end
      done_at = n - 1;
      if (!got) begin
         checks++; failures++;
         $display("FAIL wait_done timeout after %0d cycles, required a job_done pulse", budget);
      end
   endtask

   task automatic do_reset();
      rst_drv = 1'b1; req_drv = 2'b00;
      cycle(); cycle();
      rst_drv = 1'b0;
   endtask

   initial begin
      int n;
      // reset state
      rst_drv = 1'b1;
      cycle();
      chk_en = 1;
      cycle();
      chk("reset_gnt", gnt, 2'b00);
      chk("reset_done", job_done, 2'b00);
      rst_drv = 1'b0;

      // single job, immediate ack
      new_job();
      req_drv = 2'b01;
      wait_done(100);
      chk("single_done_cycle", done_at, 21);
      chk("single_done_val", last_done, 2'b01);
      chk("single_gnt", job_gnt, 2'b01);
      chk("single_clr_cycles", job_rst_cycles, 2);
      chk("single_handshakes", job_hs, 16);
      req_drv = 2'b00;
      cycle();
      chk("single_done_width", job_done_cycles, 1);
      chk("single_gnt_release", last_gnt, 2'b00);

      // simultaneous requests alternate 01,10,01
      do_reset();
      req_drv = 2'b11;
      for (int k = 0; k < 3; k++) begin
         new_job();
         wait_done(100);
         chk($sformatf("rr_job%0d", k), job_gnt, (k == 1) ? 2'b10 : 2'b01);
      end
      req_drv = 2'b00;
      cycle();

      // ack stall on (2,3) with early core_done
      do_reset();
      ack_mode = 2; early_mode = 1;
      new_job();
      req_drv = 2'b01;
      wait_done(150);
      chk("stall_cycles", stall_seen, 5);
      chk("stall_handshakes", job_hs, 16);
      chk("stall_done_val", last_done, 2'b01);
      req_drv = 2'b00;
      cycle();
      ack_mode = 0; early_mode = 0;

      // reset mid-RUN after 7 results, then a full job for requester 1
      do_reset();
      new_job();
      req_drv = 2'b01;
      n = 0;
      while (job_hs < 7 && n < 100) begin
         cycle();
         n++;
      end
      chk("midrst_reached7", job_hs, 7);
      req_drv = 2'b00; rst_drv = 1'b1;
      cycle();
      chk("midrst_core_rst", last_core_rst, 1'b1);
      rst_drv = 1'b0;
      cycle();
      chk("midrst_gnt", last_gnt, 2'b00);
      chk("midrst_start", last_start, 1'b0);
      chk("midrst_no_done", job_done_cycles, 0);
      new_job();
      req_drv = 2'b10;
      wait_done(100);
      chk("midrst_new_gnt", job_gnt, 2'b10);
      chk("midrst_new_hs", job_hs, 16);
      req_drv = 2'b00;
      cycle();

      // req drop 3 cycles into RUN, fixed operands for the mux
      ops_fixed = 1;
      new_job();
      req_drv = 2'b10;
      for (int k = 0; k < 6; k++) cycle();
      chk("mux_granted1", last_core_a, 9);
      req_drv = 2'b00;
      wait_done(100);
      chk("drop_done_val", last_done, 2'b10);
      chk("drop_handshakes", job_hs, 16);
      cycle();
      chk("mux_idle", last_core_a, 0);
      ops_fixed = 0;

      // randomized traffic
      ack_mode = 1; early_mode = 2;
      for (int k = 0; k < 4000; k++) begin
         if ($urandom_range(0, 7) == 0) req_drv = 2'($urandom_range(0, 3));
         rst_drv = ($urandom_range(0, 499) == 0);
         cycle();
      end
      rst_drv = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
